// File: rtl/id_ex_pkg.sv
// Shared ID/EX definitions: default field widths, packed payload layout and helpers.
// Reused by the control unit and the forwarding logic.
package id_ex_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ALUC_W = 4;
  localparam int unsigned REGN_W = 5;

  localparam int unsigned PAYLOAD_W = 5 + ALUC_W + REGN_W + 3 * DATA_W;

  // Bit offsets (LSB) of each field inside the packed payload, default widths
  localparam int unsigned IMME_LSB   = 0;
  localparam int unsigned QB_LSB     = IMME_LSB + DATA_W;
  localparam int unsigned QA_LSB     = QB_LSB + DATA_W;
  localparam int unsigned WN_LSB     = QA_LSB + DATA_W;
  localparam int unsigned ALUIMM_BIT = WN_LSB + REGN_W;
  localparam int unsigned SHIFT_BIT  = ALUIMM_BIT + 1;
  localparam int unsigned ALUC_LSB   = SHIFT_BIT + 1;
  localparam int unsigned WMEM_BIT   = ALUC_LSB + ALUC_W;
  localparam int unsigned M2REG_BIT  = WMEM_BIT + 1;
  localparam int unsigned WREG_BIT   = M2REG_BIT + 1;

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [ALUC_W-1:0] aluc;
    logic              shift;
    logic              aluimm;
    logic [REGN_W-1:0] wn;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [DATA_W-1:0] imme_or_sa;
  } id_ex_payload_t;

  function automatic int unsigned payload_w(input int unsigned dw,
                                            input int unsigned aw,
                                            input int unsigned rw);
    return 5 + aw + rw + 3 * dw;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register with a valid bit; sync clear beats load, data holds on clear.
module pipe_skid_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, optional skid slot,
// bubble gating of side-effect controls and a saturating bubble counter.
module id_ex_pipe_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W = id_ex_pkg::DATA_W,
  parameter int unsigned REGN_W = id_ex_pkg::REGN_W,
  parameter int unsigned ALUC_W = id_ex_pkg::ALUC_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              shift,
  input  logic              aluimm,
  input  logic [ALUC_W-1:0] aluc,
  input  logic [REGN_W-1:0] wn,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  input  logic [DATA_W-1:0] immeOrSa,
  input  logic              out_ready,
  output logic              EXvalid,
  output logic              EXwreg,
  output logic              EXm2reg,
  output logic              EXwmem,
  output logic              EXshift,
  output logic              EXaluimm,
  output logic [ALUC_W-1:0] EXaluc,
  output logic [REGN_W-1:0] EXwn,
  output logic [DATA_W-1:0] EXqa,
  output logic [DATA_W-1:0] EXqb,
  output logic [DATA_W-1:0] EXimmeOrSa,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned PW = payload_w(DATA_W, ALUC_W, REGN_W);

  logic [PW-1:0]    in_payload, main_d_in, main_data, skid_data;
  logic             main_valid, skid_valid;
  logic             main_load, main_clear, skid_load, skid_clear;
  logic             accept, consume;
  logic             ex_wreg_raw, ex_m2reg_raw, ex_wmem_raw;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_payload = {wreg, m2reg, wmem, aluc, shift, aluimm, wn, qa, qb, immeOrSa};

  // Handshake and slot steering; flush overrides every other action
  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_d_in  = in_payload;
    if (SKID != 0) begin
      in_ready = ~flush & ~skid_valid;
    end else begin
      in_ready = ~flush & (~main_valid | out_ready);
    end
    accept  = in_valid & in_ready;
    consume = main_valid & out_ready;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (skid_valid && consume) begin
      main_load  = 1'b1;
      main_d_in  = skid_data;
      skid_clear = 1'b1;
    end else if (accept && (!main_valid || consume)) begin
      main_load = 1'b1;
    end else if (accept) begin
      skid_load = 1'b1;
    end else if (consume) begin
      main_clear = 1'b1;
    end
  end

  pipe_skid_slot #(.W(PW)) u_main (
    .clk   (clk),
    .clr   (clr),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d_in),
    .valid (main_valid),
    .q     (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .clr   (clr),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_payload),
        .valid (skid_valid),
        .q     (skid_data)
      );
    end else begin : g_no_skid
      logic unused_skid_ctl;
      assign skid_valid      = 1'b0;
      assign skid_data       = '0;
      assign unused_skid_ctl = ^{skid_load, skid_clear};
    end
  endgenerate

  assign {ex_wreg_raw, ex_m2reg_raw, ex_wmem_raw, EXaluc, EXshift, EXaluimm,
          EXwn, EXqa, EXqb, EXimmeOrSa} = main_data;

  // A bubble must never write the register file or memory
  assign EXvalid  = main_valid;
  assign EXwreg   = ex_wreg_raw  & main_valid;
  assign EXm2reg  = ex_m2reg_raw & main_valid;
  assign EXwmem   = ex_wmem_raw  & main_valid;

  always_comb begin
    cnt_d = cnt_q;
    if (out_ready && !main_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench: three stage variants on shared stimulus, checked against a FIFO-style model.
module tb_id_ex_pipe_stage;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [3:0]  aluc;
    logic        shift;
    logic        aluimm;
    logic [4:0]  wn;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
  } pl_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] qa;
    logic        exp_rdy;
    logic        exp_val;
    logic [31:0] exp_qa;
  } vec_t;

  logic        clk = 1'b0;
  logic        clr, flush, in_valid, out_ready;
  logic        wreg, m2reg, wmem, shift, aluimm;
  logic [3:0]  aluc;
  logic [4:0]  wn;
  logic [31:0] qa, qb, imm;

  logic [2:0]  o_rdy, o_val, o_wreg, o_m2reg, o_wmem, o_shift, o_aluimm;
  logic [3:0]  o_aluc [3];
  logic [4:0]  o_wn   [3];
  logic [31:0] o_qa   [3];
  logic [31:0] o_qb   [3];
  logic [31:0] o_imm  [3];
  logic [15:0] o_bc0, o_bc1;
  logic [2:0]  o_bc3;

  int n_chk = 0;
  int n_fail = 0;

  // Model: each variant is a queue of held entries; index 1 is the skid-less variant
  pl_t         ent  [3][2];
  int          n    [3];
  pl_t         last [3];
  int unsigned bc   [3];
  int unsigned bcmax[3] = '{65535, 65535, 7};

  always #5 clk = ~clk;

  id_ex_pipe_stage #(.SKID(1), .CNT_W(16)) u_dut (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .shift(shift), .aluimm(aluimm),
    .aluc(aluc), .wn(wn), .qa(qa), .qb(qb), .immeOrSa(imm), .out_ready(out_ready),
    .EXvalid(o_val[0]), .EXwreg(o_wreg[0]), .EXm2reg(o_m2reg[0]), .EXwmem(o_wmem[0]),
    .EXshift(o_shift[0]), .EXaluimm(o_aluimm[0]), .EXaluc(o_aluc[0]), .EXwn(o_wn[0]),
    .EXqa(o_qa[0]), .EXqb(o_qb[0]), .EXimmeOrSa(o_imm[0]), .bubble_cnt(o_bc0));

  id_ex_pipe_stage #(.SKID(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .shift(shift), .aluimm(aluimm),
    .aluc(aluc), .wn(wn), .qa(qa), .qb(qb), .immeOrSa(imm), .out_ready(out_ready),
    .EXvalid(o_val[1]), .EXwreg(o_wreg[1]), .EXm2reg(o_m2reg[1]), .EXwmem(o_wmem[1]),
    .EXshift(o_shift[1]), .EXaluimm(o_aluimm[1]), .EXaluc(o_aluc[1]), .EXwn(o_wn[1]),
    .EXqa(o_qa[1]), .EXqb(o_qb[1]), .EXimmeOrSa(o_imm[1]), .bubble_cnt(o_bc1));

  id_ex_pipe_stage #(.SKID(1), .CNT_W(3)) u_dut3 (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[2]),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .shift(shift), .aluimm(aluimm),
    .aluc(aluc), .wn(wn), .qa(qa), .qb(qb), .immeOrSa(imm), .out_ready(out_ready),
    .EXvalid(o_val[2]), .EXwreg(o_wreg[2]), .EXm2reg(o_m2reg[2]), .EXwmem(o_wmem[2]),
    .EXshift(o_shift[2]), .EXaluimm(o_aluimm[2]), .EXaluc(o_aluc[2]), .EXwn(o_wn[2]),
    .EXqa(o_qa[2]), .EXqb(o_qb[2]), .EXimmeOrSa(o_imm[2]), .bubble_cnt(o_bc3));

  task automatic chk(input string name, input int i, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: actual=%0h required=%0h", name, i, $time, act, exp);
    end
  endtask

  function automatic pl_t cur_pl();
    pl_t p;
    p.wreg = wreg;   p.m2reg = m2reg; p.wmem = wmem; p.aluc = aluc;
    p.shift = shift; p.aluimm = aluimm; p.wn = wn;
    p.qa = qa;       p.qb = qb;       p.imm = imm;
    return p;
  endfunction

  function automatic bit m_ready(input int i);
    if (flush) return 1'b0;
    if (i == 1) return (n[i] == 0) || out_ready;
    return n[i] < 2;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      n[i] = 0; bc[i] = 0; last[i] = '0;
    end
  endtask

  task automatic check_out(input int i);
    logic [2:0]   g;
    logic [106:0] u_act, u_exp;
    logic [15:0]  bca;
    g = (n[i] > 0) ? {last[i].wreg, last[i].m2reg, last[i].wmem} : 3'b000;
    u_act = {o_aluc[i], o_shift[i], o_aluimm[i], o_wn[i], o_qa[i], o_qb[i], o_imm[i]};
    u_exp = {last[i].aluc, last[i].shift, last[i].aluimm, last[i].wn,
             last[i].qa, last[i].qb, last[i].imm};
    bca = (i == 0) ? o_bc0 : (i == 1) ? o_bc1 : 16'(o_bc3);
    chk("EXvalid", i, 128'(o_val[i]), 128'(n[i] > 0));
    chk("gated_ctl", i, 128'({o_wreg[i], o_m2reg[i], o_wmem[i]}), 128'(g));
    chk("payload", i, 128'(u_act), 128'(u_exp));
    chk("bubble_cnt", i, 128'(bca), 128'(bc[i]));
  endtask

  // One clock: check readiness before the edge, advance model, check outputs after it
  task automatic cyc();
    bit  acc[3];
    bit  con[3];
    pl_t p;
    #1;
    p = cur_pl();
    for (int i = 0; i < 3; i++) begin
      chk("in_ready", i, 128'(o_rdy[i]), 128'(m_ready(i)));
      acc[i] = in_valid && m_ready(i);
      con[i] = (n[i] > 0) && out_ready;
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (out_ready && n[i] == 0 && bc[i] < bcmax[i]) bc[i]++;
      if (flush) begin
        n[i] = 0;
      end else begin
        if (con[i]) begin
          ent[i][0] = ent[i][1];
          n[i]--;
        end
        if (acc[i]) begin
          ent[i][n[i]] = p;
          n[i]++;
        end
      end
      if (n[i] > 0) last[i] = ent[i][0];
    end
    #1;
    for (int i = 0; i < 3; i++) check_out(i);
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; out_ready = 0;
    wreg = 0; m2reg = 0; wmem = 0; shift = 0; aluimm = 0;
    aluc = '0; wn = '0; qa = '0; qb = '0; imm = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    clr = 1'b1;
    #3;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      check_out(i);
      chk("rst_in_ready", i, 128'(o_rdy[i]), 128'(1));
    end
    clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{1'b1, 1'b0, 32'h10, 1'b1, 1'b1, 32'h10};
    tbl[1] = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 32'h10};
    tbl[2] = '{1'b1, 1'b0, 32'h12, 1'b0, 1'b1, 32'h10};
    tbl[3] = '{1'b1, 1'b1, 32'h12, 1'b0, 1'b1, 32'h11};
    tbl[4] = '{1'b1, 1'b1, 32'h12, 1'b1, 1'b1, 32'h12};
    tbl[5] = '{1'b0, 1'b1, 32'h12, 1'b1, 1'b0, 32'h12};
    tbl[6] = '{1'b0, 1'b0, 32'h12, 1'b1, 1'b0, 32'h12};

    clear_inputs();
    clr = 1'b1;
    #6;
    do_reset();

    // Bubble counter: idle with execute ready
    out_ready = 1;
    for (int k = 0; k < 5; k++) cyc();
    chk("bubble5", 0, 128'(o_bc0), 128'(5));
    for (int k = 0; k < 5; k++) cyc();
    chk("bubble10", 0, 128'(o_bc0), 128'(10));
    chk("bubble_sat", 2, 128'(o_bc3), 128'(7));

    // Reset then back-to-back load
    do_reset();
    in_valid = 1; out_ready = 1; wreg = 1; qa = 32'h2; qb = 32'h3;
    cyc();
    for (int i = 0; i < 2; i++) begin
      chk("load_val", i, 128'(o_val[i]), 128'(1));
      chk("load_qa", i, 128'(o_qa[i]), 128'(32'h2));
      chk("load_qb", i, 128'(o_qb[i]), 128'(32'h3));
      chk("load_wreg", i, 128'(o_wreg[i]), 128'(1));
    end
    qa = 32'h4; qb = 32'h5;
    cyc();
    for (int i = 0; i < 2; i++) begin
      chk("b2b_val", i, 128'(o_val[i]), 128'(1));
      chk("b2b_qa", i, 128'(o_qa[i]), 128'(32'h4));
      chk("b2b_qb", i, 128'(o_qb[i]), 128'(32'h5));
    end

    // Skid stall/drain sequence from the table
    do_reset();
    for (int r = 0; r < 7; r++) begin
      in_valid = tbl[r].iv; out_ready = tbl[r].ordy; qa = tbl[r].qa;
      #1;
      chk("tbl_rdy", r, 128'(o_rdy[0]), 128'(tbl[r].exp_rdy));
      cyc();
      chk("tbl_val", r, 128'(o_val[0]), 128'(tbl[r].exp_val));
      chk("tbl_qa", r, 128'(o_qa[0]), 128'(tbl[r].exp_qa));
    end

    // Skid-less variant: ready follows out_ready combinationally while full
    do_reset();
    in_valid = 1; qa = 32'h20;
    cyc();
    in_valid = 0; out_ready = 0;
    #1;
    chk("s0_stall_rdy", 1, 128'(o_rdy[1]), 128'(0));
    out_ready = 1;
    #1;
    chk("s0_release_rdy", 1, 128'(o_rdy[1]), 128'(1));
    cyc();

    // Flush with main and skid full and a new entry presented
    do_reset();
    in_valid = 1; wreg = 1; wmem = 1; qa = 32'h30;
    cyc();
    qa = 32'h31;
    cyc();
    qa = 32'h99; flush = 1;
    cyc();
    flush = 0; in_valid = 0;
    chk("flush_val", 0, 128'(o_val[0]), 128'(0));
    chk("flush_wreg", 0, 128'(o_wreg[0]), 128'(0));
    chk("flush_wmem", 0, 128'(o_wmem[0]), 128'(0));
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("flush_no99", 0, 128'(o_qa[0] == 32'h99), 128'(0));
    end

    // Asynchronous reset between edges while stalled with skid full
    in_valid = 1; out_ready = 0; wreg = 1; qa = 32'h40;
    cyc();
    qa = 32'h41;
    cyc();
    in_valid = 0;
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("arst_val", 0, 128'(o_val[0]), 128'(0));
    chk("arst_wreg", 0, 128'(o_wreg[0]), 128'(0));
    chk("arst_bc", 0, 128'(o_bc0), 128'(0));
    chk("arst_rdy", 0, 128'(o_rdy[0]), 128'(1));
    model_reset();
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      wreg = 1'($urandom); m2reg = 1'($urandom); wmem = 1'($urandom);
      shift = 1'($urandom); aluimm = 1'($urandom);
      aluc = 4'($urandom); wn = 5'($urandom);
      qa = $urandom; qb = $urandom; imm = $urandom;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
